// File: rtl/m92_video_pkg.sv
// m92_video_pkg: shared definitions for the M92 palette/mixer slice.
//   PAL_ENTRIES / PAL_AW : palette RAM depth (two banks of 2048) and address width
//   R_LSB/G_LSB/B_LSB    : xBGR555 field offsets within a palette word
//   cpu_state_t          : CPU palette access FSM states
//   cpu_req_t            : CPU request captured at the request edge
//   vid_timing_t         : sync/blank bundle carried down the video pipe
//   expand5to8           : 5-bit to 8-bit channel expansion
package m92_video_pkg;

    localparam int PAL_ENTRIES = 4096;
    localparam int PAL_AW      = 12;
    localparam int COL_W       = 11;

    localparam int R_LSB = 0;
    localparam int G_LSB = 5;
    localparam int B_LSB = 10;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} cpu_state_t;

    typedef struct packed {
        logic             we;
        logic             bank;
        logic [COL_W-1:0] addr;
        logic [15:0]      din;
    } cpu_req_t;

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
    } vid_timing_t;

    // Blanked, sync inactive: what the pipe holds coming out of reset.
    localparam vid_timing_t TIMING_RST = '{hblank: 1'b1, vblank: 1'b1, hsync: 1'b0, vsync: 1'b0};

    // Replicate the top bits into the low bits so 0x1F maps to 0xFF and 0 to 0.
    function automatic logic [7:0] expand5to8(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/m92_pal_mixer_if.sv
// m92_pal_mixer_if: CPU palette bus.
//   pal_cs/pal_rd/pal_wr : select and strobes (an access starts on their rising edge)
//   cpu_addr/cpu_din     : word address within the current bank, write data
//   cpu_dout             : read data, valid after busy drops
//   busy                 : access in progress, CPU must stall
// master = CPU side, slave = palette block.
interface m92_pal_mixer_if;
    logic        pal_cs;
    logic        pal_rd;
    logic        pal_wr;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        busy;

    modport master (output pal_cs, pal_rd, pal_wr, cpu_addr, cpu_din,
                    input  cpu_dout, busy);
    modport slave  (input  pal_cs, pal_rd, pal_wr, cpu_addr, cpu_din,
                    output cpu_dout, busy);
endinterface

// File: rtl/m92_pal_ram.sv
// m92_pal_ram: 4096x16 dual-port palette RAM.
//   clk                 : clock
//   a_en/a_addr/a_q     : video port, read-only, synchronous
//   b_en/b_we/b_addr/
//   b_din/b_q           : CPU port, read/write, synchronous
// Both ports are read-before-write: a read colliding with a write to the
// same entry returns the old contents. Contents are never cleared.
module m92_pal_ram
    import m92_video_pkg::*;
(
    input  logic              clk,
    input  logic              a_en,
    input  logic [PAL_AW-1:0] a_addr,
    output logic [15:0]       a_q,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [PAL_AW-1:0] b_addr,
    input  logic [15:0]       b_din,
    output logic [15:0]       b_q
);

    logic [15:0] mem [PAL_ENTRIES];

    always_ff @(posedge clk) begin
        if (a_en) a_q <= mem[a_addr];
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            b_q <= mem[b_addr];
            if (b_we) mem[b_addr] <= b_din;
        end
    end

endmodule

// File: rtl/m92_pal_mixer.sv
// m92_pal_mixer: tile/sprite priority mixer, palette lookup and RGB888 output.
//   clk, reset          : clock, synchronous active-high reset
//   ce_pix              : pixel clock enable; all video stages advance on it
//   cpu                 : CPU palette bus (slave side)
//   pal_bank            : palette bank for video (stage 1) and CPU (at request)
//   tile_*/spr_*        : tilemap and sprite pixels (transparent when [3:0]==0)
//   *_in                : timing from the video timing generator
//   red/green/blue      : RGB888, forced to 0 while blanked
//   hblank..vsync       : timing delayed by PIPE_DEPTH ticks
// Video pipe: stage 1 mix -> palette address, stage 2 RAM read, stage 3 expand.
module m92_pal_mixer
    import m92_video_pkg::*;
#(
    parameter int PIPE_DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    m92_pal_mixer_if.slave    cpu,
    input  logic              pal_bank,
    input  logic [COL_W-1:0]  tile_color,
    input  logic              tile_prio,
    input  logic [COL_W-1:0]  spr_color,
    input  logic              spr_prio,
    input  logic              hblank_in,
    input  logic              vblank_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hblank,
    output logic              vblank,
    output logic              hsync,
    output logic              vsync
);

    // ---------------- video pipe ----------------
    logic              tile_opaque, spr_opaque, spr_win;
    logic [COL_W-1:0]  winner;
    logic [PAL_AW-1:0] vid_addr;
    logic [15:0]       vid_q;
    logic              vid_q_unused;
    vid_timing_t       tim_in;
    vid_timing_t [PIPE_DEPTH-1:0] tim_pipe;

    assign tile_opaque = |tile_color[3:0];
    assign spr_opaque  = |spr_color[3:0];
    // A transparent tile loses to any opaque sprite; a transparent winner
    // tile still indexes the palette (index 0 is the backdrop).
    assign spr_win     = spr_opaque & (spr_prio | ~tile_prio | ~tile_opaque);
    assign winner      = spr_win ? spr_color : tile_color;
    assign tim_in      = '{hblank: hblank_in, vblank: vblank_in, hsync: hsync_in, vsync: vsync_in};
    assign vid_q_unused = vid_q[15];

    always_ff @(posedge clk) begin
        if (reset) begin
            vid_addr <= '0;
            tim_pipe <= {PIPE_DEPTH{TIMING_RST}};
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else if (ce_pix) begin
            vid_addr <= {pal_bank, winner};
            tim_pipe <= {tim_pipe[PIPE_DEPTH-2:0], tim_in};
            // Stage 3 loads alongside the last timing stage, so blank is
            // taken from the stage that is about to reach the output.
            if (tim_pipe[PIPE_DEPTH-2].hblank | tim_pipe[PIPE_DEPTH-2].vblank) begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end else begin
                red   <= expand5to8(vid_q[R_LSB +: 5]);
                green <= expand5to8(vid_q[G_LSB +: 5]);
                blue  <= expand5to8(vid_q[B_LSB +: 5]);
            end
        end
    end

    assign hblank = tim_pipe[PIPE_DEPTH-1].hblank;
    assign vblank = tim_pipe[PIPE_DEPTH-1].vblank;
    assign hsync  = tim_pipe[PIPE_DEPTH-1].hsync;
    assign vsync  = tim_pipe[PIPE_DEPTH-1].vsync;

    // ---------------- CPU access FSM ----------------
    cpu_state_t state, state_nx;
    cpu_req_t   req_lat;
    logic       req, req_q, req_edge;
    logic       b_en, b_we, dout_ld;
    logic [15:0] b_q, dout_r;

    assign req      = cpu.pal_cs & (cpu.pal_rd | cpu.pal_wr);
    assign req_edge = req & ~req_q & ~reset;

    // req_q tracks the strobes even in reset, so a request held across
    // reset is not mistaken for a new edge.
    always_ff @(posedge clk) begin
        req_q <= req;
        if (reset) begin
            state  <= IDLE;
            dout_r <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_edge)
                req_lat <= '{we: cpu.pal_wr, bank: pal_bank, addr: cpu.cpu_addr, din: cpu.cpu_din};
            if (dout_ld) dout_r <= b_q;
        end
    end

    always_comb begin
        state_nx = state;
        cpu.busy = 1'b0;
        b_en     = 1'b0;
        b_we     = 1'b0;
        dout_ld  = 1'b0;
        case (state)
            IDLE: begin
                if (req_edge) begin
                    cpu.busy = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                cpu.busy = 1'b1;
                b_en     = 1'b1;
                b_we     = req_lat.we;
                state_nx = DONE;
            end
            DONE: begin
                cpu.busy = 1'b1;
                dout_ld  = ~req_lat.we;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cpu.cpu_dout = dout_r;

    m92_pal_ram u_ram (
        .clk    (clk),
        .a_en   (ce_pix),
        .a_addr (vid_addr),
        .a_q    (vid_q),
        .b_en   (b_en),
        .b_we   (b_we),
        .b_addr ({req_lat.bank, req_lat.addr}),
        .b_din  (req_lat.din),
        .b_q    (b_q)
    );

endmodule

// File: tb/tb_m92_pal_mixer.sv
// tb_m92_pal_mixer: scoreboard bench for m92_pal_mixer. Drivers push expected
// CPU read data and expected video pixels into queues; two monitors pop and
// compare when busy drops / when a pixel reaches the output tick.
module tb_m92_pal_mixer;
    import m92_video_pkg::*;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic        hb;
        logic        vb;
        logic        hs;
    } vexp_t;

    logic        clk = 0, reset = 1, ce_pix = 0;
    logic        pal_bank = 0;
    logic [10:0] tile_color = 0, spr_color = 0;
    logic        tile_prio = 0, spr_prio = 0;
    logic        hblank_in = 1, vblank_in = 1, hsync_in = 0, vsync_in = 0;
    logic [7:0]  red, green, blue;
    logic        hblank, vblank, hsync, vsync;

    int          tick_cnt = 0;
    int          n_cmp = 0, n_err = 0;
    vexp_t       vq[$];
    logic [15:0] cq[$];

    m92_pal_mixer_if bus();

    m92_pal_mixer #(.PIPE_DEPTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .cpu        (bus),
        .pal_bank   (pal_bank),
        .tile_color (tile_color),
        .tile_prio  (tile_prio),
        .spr_color  (spr_color),
        .spr_prio   (spr_prio),
        .hblank_in  (hblank_in),
        .vblank_in  (vblank_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hblank     (hblank),
        .vblank     (vblank),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    // ce_pix is high every other clk; tick_cnt counts enabled edges.
    always begin
        #5 clk = 1;
        if (ce_pix) tick_cnt++;
        #5 clk = 0;
        ce_pix = ~ce_pix;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (!bus.busy) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL busy_timeout: busy stuck high");
        end
    endtask

    task automatic cpu_op(input logic wr, input logic bk, input logic [10:0] a, input logic [15:0] d);
        @(negedge clk); #1;
        if (!wr) cq.push_back(d);
        bus.pal_cs = 1; bus.pal_rd = ~wr; bus.pal_wr = wr;
        bus.cpu_addr = a; bus.cpu_din = wr ? d : 16'h0; pal_bank = bk;
        wait_idle();
        bus.pal_cs = 0; bus.pal_rd = 0; bus.pal_wr = 0;
        @(negedge clk); #1;
    endtask

    task automatic vid_px(input logic bk, input logic [10:0] tc, input logic tp,
                          input logic [10:0] sc, input logic sp,
                          input logic hb, input logic vb, input logic hs,
                          input logic [23:0] rgb);
        vexp_t e;
        do begin @(negedge clk); #1; end while (!ce_pix);
        pal_bank = bk; tile_color = tc; tile_prio = tp; spr_color = sc; spr_prio = sp;
        hblank_in = hb; vblank_in = vb; hsync_in = hs; vsync_in = 0;
        e.due = tick_cnt + 3; e.rgb = rgb; e.hb = hb; e.vb = vb; e.hs = hs;
        vq.push_back(e);
    endtask

    // CPU monitor: measures busy width and checks read data when busy drops.
    bit          m_bp = 0, m_isrd = 0;
    int          m_cnt = 0;
    logic [15:0] m_exp;
    initial forever begin
        @(negedge clk); #2;
        if (reset) begin
            m_bp = 0; m_cnt = 0;
        end else begin
            if (bus.busy && !m_bp) begin
                m_cnt = 1; m_isrd = bus.pal_rd;
            end else if (bus.busy) begin
                m_cnt++;
            end else if (m_bp) begin
                chk("busy_len", m_cnt, 3);
                if (m_isrd) begin
                    if (cq.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL cpu_unexpected_read: dout %h with no expectation", bus.cpu_dout);
                    end else begin
                        m_exp = cq.pop_front();
                        chk("cpu_dout", bus.cpu_dout, m_exp);
                    end
                end
            end
            m_bp = bus.busy;
        end
    end

    // Video monitor: once per tick, compare the pixel due at this tick.
    int    v_last = 0;
    vexp_t v_e;
    initial forever begin
        @(negedge clk); #2;
        if (tick_cnt != v_last) begin
            v_last = tick_cnt;
            if (vq.size() > 0 && vq[0].due <= tick_cnt) begin
                v_e = vq.pop_front();
                chk("vid_tick",   tick_cnt, v_e.due);
                chk("vid_rgb",    {red, green, blue}, v_e.rgb);
                chk("vid_hblank", hblank, v_e.hb);
                chk("vid_vblank", vblank, v_e.vb);
                chk("vid_hsync",  hsync, v_e.hs);
            end
        end
    end

    bit busy_seen;

    initial begin
        bus.pal_cs = 0; bus.pal_rd = 0; bus.pal_wr = 0; bus.cpu_addr = 0; bus.cpu_din = 0;
        repeat (3) @(negedge clk);
        #1 reset = 0;
        @(negedge clk); #1;
        chk("rst_rgb",    {red, green, blue}, 24'h0);
        chk("rst_hblank", hblank, 1);
        chk("rst_vblank", vblank, 1);
        chk("rst_hsync",  hsync, 0);
        chk("rst_vsync",  vsync, 0);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_dout",   bus.cpu_dout, 16'h0);

        // Palette programming and readback.
        cpu_op(1, 0, 11'h123, 16'h7C1F);
        cpu_op(0, 0, 11'h123, 16'h7C1F);
        cpu_op(1, 0, 11'h045, 16'h001F);
        cpu_op(1, 0, 11'h012, 16'h0010);
        cpu_op(1, 0, 11'h301, 16'h4000);
        cpu_op(1, 0, 11'h000, 16'h0001);
        cpu_op(1, 1, 11'h045, 16'h03E0);
        cpu_op(0, 1, 11'h045, 16'h03E0);
        cpu_op(0, 0, 11'h045, 16'h001F);

        //     bank tile    tp sprite  sp hb vb hs  rgb
        vid_px(0, 11'h045, 0, 11'h000, 0, 0, 0, 1, 24'hFF0000);
        vid_px(0, 11'h012, 1, 11'h301, 0, 0, 0, 0, 24'h840000);
        vid_px(0, 11'h012, 1, 11'h301, 1, 0, 0, 0, 24'h000084);
        vid_px(0, 11'h012, 0, 11'h301, 0, 0, 0, 0, 24'h000084);
        vid_px(0, 11'h010, 1, 11'h301, 0, 0, 0, 0, 24'h000084);
        vid_px(0, 11'h000, 0, 11'h010, 1, 0, 0, 0, 24'h080000);
        vid_px(0, 11'h123, 0, 11'h000, 0, 0, 0, 0, 24'hFF00FF);
        vid_px(1, 11'h045, 0, 11'h000, 0, 0, 0, 0, 24'h00FF00);
        vid_px(1, 11'h045, 0, 11'h000, 0, 1, 0, 0, 24'h000000);
        vid_px(1, 11'h045, 0, 11'h000, 0, 0, 0, 0, 24'h00FF00);
        vid_px(0, 11'h045, 0, 11'h000, 0, 0, 1, 0, 24'h000000);
        vid_px(1, 11'h045, 0, 11'h000, 0, 0, 0, 0, 24'h00FF00);

        for (int i = 0; i < 40 && vq.size() > 0; i++) @(negedge clk);
        chk("vid_drained", vq.size(), 0);
        repeat (4) @(negedge clk);

        // Reset while in ACCESS aborts the read; no expectation is queued.
        #1;
        bus.pal_cs = 1; bus.pal_rd = 1; bus.cpu_addr = 11'h045; pal_bank = 1;
        @(negedge clk); #1;
        chk("access_busy", bus.busy, 1);
        reset = 1;
        @(posedge clk); #1;
        chk("abort_busy",   bus.busy, 0);
        chk("abort_rgb",    {red, green, blue}, 24'h0);
        chk("abort_hblank", hblank, 1);
        chk("abort_dout",   bus.cpu_dout, 16'h0);
        @(negedge clk); @(negedge clk); #1;
        reset = 0;

        busy_seen = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (bus.busy) busy_seen = 1;
        end
        chk("held_rd_idle", busy_seen, 0);

        bus.pal_cs = 0; bus.pal_rd = 0;
        @(negedge clk); #1;
        cq.push_back(16'h03E0);
        bus.pal_cs = 1; bus.pal_rd = 1;
        wait_idle();
        bus.pal_cs = 0; bus.pal_rd = 0;
        repeat (4) @(negedge clk);

        chk("cpu_drained", cq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/m92_pal_mixer.md
# m92_pal_mixer

Pixel mixer and palette stage directly downstream of the tilemap generator. Each pixel it merges the tilemap pixel (11-bit colour plus priority flag) with the sprite pixel by priority and transparency. It then looks the winner up in a CPU-writable 2×2048-entry xBGR555 palette RAM and emits RGB888 with the sync and blank signals delayed to match. It also owns the CPU read/write path to palette RAM, including a busy handshake.

## Interface
Parameters:
- PIPE_DEPTH, 3, video latency in ce_pix ticks; fixed, exposed for bench alignment only.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- ce_pix  in  1  pixel clock enable
- pal_cs  in  1  CPU palette select
- pal_rd  in  1  CPU read strobe
- pal_wr  in  1  CPU write strobe
- cpu_addr  in  11  CPU word address within the current bank
- cpu_din  in  16  CPU write data
- cpu_dout  out  16  CPU read data
- busy  out  1  CPU access in progress; CPU must stall
- pal_bank  in  1  palette bank select for both video and CPU
- tile_color  in  11  tilemap pixel colour; transparent when [3:0]==0
- tile_prio  in  1  tilemap pixel priority
- spr_color  in  11  sprite pixel colour; transparent when [3:0]==0
- spr_prio  in  1  sprite over high-priority tile when 1
- hblank_in, vblank_in, hsync_in, vsync_in  in  1 each  timing from the video timing generator
- red, green, blue  out  8 each  pixel colour
- hblank, vblank, hsync, vsync  out  1 each  timing delayed by PIPE_DEPTH ticks

## Operation
- Mix, computed on stage 1 at ce_pix:
  - The sprite wins if sprite is opaque AND (spr_prio OR ~tile_prio OR tile transparent).
  - Otherwise the tile wins, even if transparent. Tile index 0 maps to palette entry 0, which serves as the backdrop.
- Palette address is {pal_bank, winner[10:0]}.
- Stage 2: synchronous RAM read on the video port.
- Stage 3 colour expansion:
  - R = d[4:0], G = d[9:5], B = d[14:10]; d[15] is ignored.
  - Each 5-bit channel c expands to 8 bits as {c, c[4:2]}.
- Blanking: if the delayed hblank OR vblank is 1, RGB outputs are forced to 0.
- CPU port uses a separate RAM port, so there is no contention with video. FSM states:
  - IDLE: on the rising edge of (pal_cs & (pal_rd|pal_wr)) with busy==0, latch addr, data, we and bank, then go to ACCESS. busy is 1 in the same cycle, combinational from the request edge.
  - ACCESS: perform the RAM write, or issue the read, at {latched bank, latched addr}, then go to DONE.
  - DONE: on a read, cpu_dout ← RAM output. Return to IDLE and drop busy.
- Request held high across multiple cycles: only one access is performed. A new access requires strobes to deassert first.
- Write and read to the same entry within one access are not supported. A CPU write to the entry that video is reading in the same cycle returns the old value to video (read-before-write).
- Reset:
  - FSM goes to IDLE; busy = 0; cpu_dout = 0.
  - Pipeline registers clear; RGB = 0.
  - Delayed hblank/vblank = 1; delayed hsync/vsync = 0.
  - Palette contents are not cleared.
  - Reset mid-access aborts the access; a write issued in ACCESS on that same cycle may or may not land.

## Timing
- Video latency is exactly 3 ce_pix ticks from input pixel to RGB; all stage registers advance only on ce_pix.
- Sync and blank inputs pass through a 3-stage shift register clocked by ce_pix, so they stay aligned with RGB.
- CPU access: busy is high for 3 clk: the request cycle, ACCESS and DONE. cpu_dout is valid from the clk after DONE and holds until the next read.
- pal_bank is sampled at stage 1 for video and latched at request time for CPU.

## Structure
- Package m92_video_pkg holds:
  - PAL_ENTRIES = 4096
  - the xBGR555 field offsets
  - the function expand5to8
  - the CPU FSM enum {IDLE, ACCESS, DONE}
- One sub-module, m92_pal_ram: dual-port 4096×16 block RAM, with port A read-only for video and port B read/write for CPU, both synchronous and read-before-write.
- The mixer, pipeline and FSM live in the top level.

## Test plan
- CPU writes 0x7C1F to entry 0x123 with bank 0, then reads it back → busy is high for 3 clk; cpu_dout = 0x7C1F.
- Entry 0x045 = 0x001F; tile_color=0x045, sprite transparent, blanks low → three ticks later RGB = FF,00,00.
- Tile 0x012 with prio=1 and sprite 0x301 with spr_prio=0 → palette address 0x012. Same inputs with spr_prio=1 → address 0x301.
- Tile and sprite both transparent (low nibble 0) → palette entry 0x000 is output.
- Program bank 1 entry 0x045 = 0x03E0; pal_bank=1 → RGB = 00,FF,00. hblank_in pulse → RGB = 0 exactly 3 ticks later, with hblank out aligned.
- Assert reset during ACCESS → busy = 0 and RGB = 0 next clk. A held pal_rd after reset does not start an access until it is deasserted and reasserted.
